// File: rtl/sm4_key_exp_ctrl.sv
// SM4 key-schedule controller: one key-expansion round per step,
// streaming rk0..rk31 over a valid/ready handshake.
module one_round_for_key_exp (
  input  logic [127:0] data_in,
  input  logic [4:0]   count_round_in,
  input  logic [31:0]  ck_parameter_in,
  output logic [127:0] result_out
);
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  logic [127:0] k;
  logic [31:0]  t;
  logic [31:0]  b;
  logic [31:0]  l;

  // FK whitening on round 0, then tau, L' and the word shift
  always_comb begin
    k = (count_round_in == 5'd0) ? (data_in ^ FK) : data_in;
    t = k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_parameter_in;
    b = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    l = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    result_out = {k[95:0], k[127:96] ^ l};
  end
endmodule

module sm4_key_exp_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk_data,
  output logic [4:0]   rk_index,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [5:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         vld_q, vld_d;
  logic         done_q, done_d;
  logic [31:0]  rk_q, rk_d;
  logic [4:0]   idx_q, idx_d;
  logic [31:0]  ck;
  logic [127:0] res;
  logic [7:0]   base;

  // CK byte j of round i is ((4i+j)*7) mod 256, MSB byte first
  always_comb begin
    ck   = '0;
    base = '0;
    for (int j = 0; j < 4; j++) begin
      base = {1'b0, round_q[4:0], 2'(j)};
      ck[31-8*j -: 8] = base * 8'd7;
    end
  end

  one_round_for_key_exp u_round (
    .data_in         (key_q),
    .count_round_in  (round_q[4:0]),
    .ck_parameter_in (ck),
    .result_out      (res)
  );

  // next-state: accept start, step rounds, retire after rk31
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    busy_d  = busy_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    rk_d    = rk_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!round_q[5] && (!vld_q || rk_ready)) begin
          key_d   = res;
          rk_d    = res[31:0];
          idx_d   = round_q[4:0];
          vld_d   = 1'b1;
          round_d = round_q + 6'd1;
        end else if (round_q[5] && vld_q && rk_ready) begin
          vld_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      rk_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = vld_q;
  assign rk_data  = rk_q;
  assign rk_index = idx_q;
  assign done     = done_q;
endmodule
